// File: rtl/gcd_engine.sv
// Binary (Stein) GCD engine with valid/ready handshakes on operand input and result output.
// One operand pair is in flight at a time; results are held until the consumer accepts them.
module gcd_engine #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(2*WIDTH+2)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd,
   output logic             coprime,
   output logic             zero_in,
   output logic [CNT_W-1:0] cycles
);

   localparam int K_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [K_W-1:0]   K_ONE   = {{(K_W-1){1'b0}}, 1'b1};
   localparam logic [K_W-1:0]   K_MAX   = {K_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] u_r;
   logic [WIDTH-1:0] v_r;
   logic [K_W-1:0]   k_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] gcd_r;
   logic             coprime_r;
   logic             zero_in_r;
   logic [CNT_W-1:0] cycles_r;
   logic             in_ready_r;
   logic             out_valid_r;

   logic [WIDTH-1:0] shifted_s;
   logic [WIDTH-1:0] diff_uv_s;
   logic [WIDTH-1:0] diff_vu_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic [K_W-1:0]   k_inc_s;
   logic             a_zero_s;
   logic             b_zero_s;

   // Datapath helpers for one Stein step; counters saturate rather than wrap.
   always_comb begin
      shifted_s = u_r << k_r;
      diff_uv_s = u_r - v_r;
      diff_vu_s = v_r - u_r;
      a_zero_s  = (a == ZERO_W);
      b_zero_s  = (b == ZERO_W);
      if (cnt_r == CNT_MAX) begin
         cnt_inc_s = cnt_r;
      end else begin
         cnt_inc_s = cnt_r + CNT_ONE;
      end
      if (k_r == K_MAX) begin
         k_inc_s = k_r;
      end else begin
         k_inc_s = k_r + K_ONE;
      end
   end

   // Control FSM, working registers and registered result fields.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         u_r         <= ZERO_W;
         v_r         <= ZERO_W;
         k_r         <= {K_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         gcd_r       <= ZERO_W;
         coprime_r   <= 1'b0;
         zero_in_r   <= 1'b0;
         cycles_r    <= {CNT_W{1'b0}};
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  u_r        <= a;
                  v_r        <= b;
                  k_r        <= {K_W{1'b0}};
                  cnt_r      <= {CNT_W{1'b0}};
                  in_ready_r <= 1'b0;
                  // A zero operand makes the answer the other operand; skip CALC.
                  if (a_zero_s || b_zero_s) begin
                     gcd_r       <= a | b;
                     zero_in_r   <= a_zero_s && b_zero_s;
                     coprime_r   <= ((a | b) == ONE_W);
                     cycles_r    <= {CNT_W{1'b0}};
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end else begin
                     state_r <= CALC;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            CALC: begin
               cnt_r <= cnt_inc_s;
               if (u_r == v_r) begin
                  gcd_r       <= shifted_s;
                  coprime_r   <= (shifted_s == ONE_W);
                  zero_in_r   <= 1'b0;
                  cycles_r    <= cnt_inc_s;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else if (!u_r[0] && !v_r[0]) begin
                  u_r <= u_r >> 1;
                  v_r <= v_r >> 1;
                  k_r <= k_inc_s;
               end else if (!u_r[0]) begin
                  u_r <= u_r >> 1;
               end else if (!v_r[0]) begin
                  v_r <= v_r >> 1;
               end else if (u_r > v_r) begin
                  u_r <= diff_uv_s >> 1;
               end else begin
                  v_r <= diff_vu_s >> 1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign gcd       = gcd_r;
   assign coprime   = coprime_r;
   assign zero_in   = zero_in_r;
   assign cycles    = cycles_r;

endmodule
